lvds_input_capture: RTL and testbench

//  Capture engine downstream of the AXI-Lite control register block of lvds_input.

---
 rtl/lvds_input_capture.sv | 158 +++++++++++++++
 tb/tb_lvds_input_capture.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lvds_input_capture.sv
// rtl/lvds_input_capture.sv - block capture of deserialised ADC samples onto an AXI4-Stream master
//
// Purpose: on a start pulse, emit one block of dsize words (ADC samples or a
// counter test pattern) through a single-stage output register. The block may
// repeat continuously while cr_rt is held. Reports busy, done and a sticky
// overflow flag.
//
// Ports:
//   ACLK, ARESETN             clock, asynchronous active-low reset
//   dsize, cr_start           block length (latched at start), start pulse
//   cr_test, cr_rt            test-pattern select (latched), continuous repeat
//   adc_data, adc_valid       sample stream, no back-pressure
//   M_AXIS_TDATA/TVALID/
//   TREADY/TLAST              stream master toward the DMA
//   busy, done, ovf           status outputs
module lvds_input_capture #(
  parameter int DATA_W = 16
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [31:0]       dsize,
  input  logic              cr_start,
  input  logic              cr_test,
  input  logic              cr_rt,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [DATA_W-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic              M_AXIS_TLAST,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [31:0]       dsize_q, dsize_d;
  logic [31:0]       issued_q, issued_d;
  logic              test_q, test_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic start_ok;
  logic load_ok;
  logic hs;
  logic want;
  logic load;
  logic last_word;

  assign start_ok  = (state_q == S_IDLE) && cr_start && (dsize != 32'd0);
  assign load_ok   = !tvalid_q || M_AXIS_TREADY;
  assign hs        = tvalid_q && M_AXIS_TREADY;
  assign want      = (state_q == S_RUN) && (issued_q < dsize_q);
  assign load      = want && load_ok && (test_q || adc_valid);
  assign last_word = (issued_q == dsize_q - 32'd1);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The move to DRAIN happens on the load of the last word, so the TLAST
  // handshake can complete in the very next cycle without being missed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN:   if (load && last_word) state_d = S_DRAIN;
      S_DRAIN: if (hs) state_d = cr_rt ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dsize_d  = dsize_q;
    test_d   = test_q;
    issued_d = issued_q;
    pat_d    = pat_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    if (start_ok) begin
      dsize_d  = dsize;
      test_d   = cr_test;
      issued_d = 32'd0;
      pat_d    = '0;
      ovf_d    = 1'b0;
    end

    if (load) begin
      tdata_d  = test_q ? pat_q : adc_data;
      tlast_d  = last_word;
      tvalid_d = 1'b1;
      issued_d = issued_q + 32'd1;
      if (test_q) pat_d = pat_q + DATA_W'(1);
    end else if (hs) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    // A sample is only "lost" while the block still needs words.
    if (want && !test_q && adc_valid && !load_ok) ovf_d = 1'b1;

    // In DRAIN the only word in flight is the TLAST word.
    if ((state_q == S_DRAIN) && hs) begin
      if (cr_rt) begin
        issued_d = 32'd0;
        pat_d    = '0;
      end else begin
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      dsize_q  <= 32'd0;
      test_q   <= 1'b0;
      issued_q <= 32'd0;
      pat_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      dsize_q  <= dsize_d;
      test_q   <= test_d;
      issued_q <= issued_d;
      pat_q    <= pat_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_lvds_input_capture.sv
// tb/tb_lvds_input_capture.sv - self-checking bench for lvds_input_capture
module tb_lvds_input_capture;

  localparam int DATA_W = 16;

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b0;
  logic [31:0]       dsize = 32'd0;
  logic              cr_start = 1'b0;
  logic              cr_test = 1'b0;
  logic              cr_rt = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              adc_valid = 1'b0;
  logic [DATA_W-1:0] M_AXIS_TDATA;
  logic              M_AXIS_TVALID;
  logic              M_AXIS_TREADY = 1'b0;
  logic              M_AXIS_TLAST;
  logic              busy;
  logic              done;
  logic              ovf;

  lvds_input_capture #(.DATA_W(DATA_W)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .dsize(dsize), .cr_start(cr_start),
    .cr_test(cr_test), .cr_rt(cr_rt), .adc_data(adc_data), .adc_valid(adc_valid),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST),
    .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a block is "active" while busy; words still owed while
  // m_cnt < m_len; the single output slot holds one word at a time.
  logic              m_busy, m_tvalid, m_tlast, m_done, m_ovf, m_test;
  logic [DATA_W-1:0] m_tdata, m_pat;
  int unsigned       m_len, m_cnt;
  int                beats;

  task automatic model_reset();
    m_busy = 0; m_tvalid = 0; m_tlast = 0; m_done = 0; m_ovf = 0; m_test = 0;
    m_tdata = '0; m_pat = '0; m_len = 0; m_cnt = 0; beats = 0;
  endtask

  task automatic model_edge();
    bit hs, room, ld;
    hs   = m_tvalid && M_AXIS_TREADY;
    room = !m_tvalid || M_AXIS_TREADY;
    ld   = 0;
    m_done = 0;
    if (!m_busy) begin
      if (cr_start && dsize != 0) begin
        m_busy = 1; m_len = dsize; m_test = cr_test; m_cnt = 0; m_pat = '0; m_ovf = 0;
      end
    end else if (m_cnt < m_len) begin
      if (m_test) ld = room;
      else if (adc_valid) begin
        if (room) ld = 1;
        else m_ovf = 1;
      end
    end else if (hs) begin
      if (cr_rt) begin m_cnt = 0; m_pat = '0; end
      else begin m_busy = 0; m_done = 1; end
    end
    if (ld) begin
      m_tdata  = m_test ? m_pat : adc_data;
      m_tlast  = (m_cnt == m_len - 1);
      m_tvalid = 1;
      m_cnt++;
      if (m_test) m_pat = m_pat + 1'b1;
    end else if (hs) begin
      m_tvalid = 0;
      m_tlast  = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".tvalid"}, 64'(M_AXIS_TVALID), 64'(m_tvalid));
    check({tag, ".tdata"},  64'(M_AXIS_TDATA),  64'(m_tdata));
    check({tag, ".tlast"},  64'(M_AXIS_TLAST),  64'(m_tlast));
    check({tag, ".busy"},   64'(busy),          64'(m_busy));
    check({tag, ".done"},   64'(done),          64'(m_done));
    check({tag, ".ovf"},    64'(ovf),           64'(m_ovf));
  endtask

  task automatic step(input string tag);
    bit          d_hs, d_last;
    int unsigned exp_len;
    d_hs    = M_AXIS_TVALID && M_AXIS_TREADY;
    d_last  = M_AXIS_TLAST;
    exp_len = m_len;
    @(posedge ACLK);
    if (!ARESETN) model_reset();
    else begin
      if (d_hs) begin
        beats++;
        if (d_last) begin
          check({tag, ".blk_len"}, 64'(beats), 64'(exp_len));
          beats = 0;
        end
      end
      model_edge();
    end
    #1;
    compare_all(tag);
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic pulse_start(input string tag);
    cr_start = 1; step(tag); cr_start = 0;
  endtask

  task automatic async_reset(input string tag);
    ARESETN = 0;
    #1;
    model_reset();
    compare_all(tag);
    #2;
    ARESETN = 1;
  endtask

  initial begin
    model_reset();
    #1;
    compare_all("reset");
    steps("reset", 2);
    #2 ARESETN = 1;
    steps("idle", 2);

    // counter pattern block
    M_AXIS_TREADY = 1; dsize = 4; cr_test = 1;
    pulse_start("t1");
    steps("t1", 8);

    // ADC block with extra sample after the block
    cr_test = 0; dsize = 3;
    adc_valid = 1; adc_data = 16'hA0A0;
    pulse_start("t2");
    for (int i = 0; i < 6; i++) begin
      adc_data = 16'hA0A1 + 16'(i);
      step("t2");
    end
    adc_valid = 0;
    steps("t2", 3);

    // stall mid-block forces overflow
    dsize = 8; adc_valid = 1;
    pulse_start("t3");
    for (int i = 0; i < 16; i++) begin
      adc_data = 16'h3000 + 16'(i);
      M_AXIS_TREADY = !(i == 3 || i == 4);
      step("t3");
    end
    adc_valid = 0; M_AXIS_TREADY = 1;
    steps("t3", 3);

    // continuous repeat, then clear rt mid-block
    dsize = 2; cr_test = 1; cr_rt = 1;
    pulse_start("t4");
    steps("t4", 9);
    cr_rt = 0;
    steps("t4", 6);

    // zero-length start, and start during RUN
    dsize = 0;
    pulse_start("t5");
    steps("t5", 3);
    dsize = 5;
    pulse_start("t5");
    steps("t5", 2);
    dsize = 9;
    pulse_start("t5");
    steps("t5", 8);

    // reset mid-block, then a fresh block
    dsize = 16; cr_test = 1;
    pulse_start("t6");
    steps("t6", 5);
    async_reset("t6.rst");
    steps("t6", 2);
    pulse_start("t6");
    steps("t6", 20);

    // randomized traffic
    for (int c = 0; c < 5000; c++) begin
      cr_start      = ($urandom_range(0, 7) == 0);
      dsize         = $urandom_range(0, 10);
      cr_test       = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) cr_rt = ~cr_rt;
      adc_valid     = ($urandom_range(0, 3) != 0);
      adc_data      = DATA_W'($urandom);
      M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 599) == 0) async_reset("rnd.rst");
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
